i2s_tx_serializer: RTL
======================

Name: i2s_tx_serializer

Overview:
- Audio DAC-side I2S transmitter. Takes processed stereo 24-bit samples from the equalizer datapath over a valid/ready handshake and serializes them onto the codec DAC data line.
- The codec is the I2S master; bclk and lrclk are inputs, asynchronous to clk.
- This is the outbound counterpart of the ADC-side I2S capture path.

Parameters:
- DATA_W, 24: sample width, two's complement, MSB first.
- SLOT_W, 32: bclk periods per channel slot; requires SLOT_W >= DATA_W + 1.
- SYNC_STAGES, 2: flip-flop synchronizer depth for bclk and lrclk.

Ports:
- clk  in  1  system clock; must be >= 8x bclk frequency.
- reset_n  in  1  asynchronous, active-low reset.
- bclk  in  1  I2S bit clock from codec, asynchronous.
- lrclk  in  1  I2S word select from codec, asynchronous; 0 = left, 1 = right.
- sample_l  in  DATA_W  left sample.
- sample_r  in  DATA_W  right sample.
- sample_valid  in  1  stereo pair presented.
- sample_ready  out  1  holding register empty; can accept a pair.
- dacdat  out  1  serial data to codec DAC.
- frame_start  out  1  one-clk pulse when a left word begins shifting.
- underflow  out  1  one-clk pulse when a left slot starts with no pair available.
- underflow_cnt  out  16  saturating count of underflow events.

Behaviour:
- Reset values: sample_ready 0, dacdat 0, frame_start 0, underflow 0, underflow_cnt 0. Holding register is empty, shift register is 0, state is IDLE.
- Reset is asynchronous and takes effect mid-word. dacdat is forced to 0 immediately, any held pair is discarded, and the block resynchronizes to the next left slot after release.
- Synchronization: bclk and lrclk pass through SYNC_STAGES flops.
  - bclk_fall is asserted on the clk cycle where the synchronized bclk goes 1 to 0.
  - lrclk is sampled only on bclk_fall.
  - lr_edge is asserted when the sampled lrclk differs from its value at the previous bclk_fall.
- Handshake:
  - sample_ready is registered. It goes to 1 on the first clk edge after reset release while the holding register is empty.
  - A transfer occurs when sample_valid and sample_ready are both 1 on a clk edge. On that edge the pair is captured into the holding register, and sample_ready is 0 from the next cycle.
  - The holding register is single-entry and stays full until consumed.
- States:
  - IDLE: dacdat stays 0. On a bclk_fall with lr_edge and new lrclk = 0, arm a load for LEFT.
  - LEFT and RIGHT: on each bclk_fall, shift the register left by one, shift in 0, and drive dacdat from the MSB.
  - On a bclk_fall with lr_edge, arm a load. On the next bclk_fall, perform the armed load. This gives the standard I2S one-bclk delay.
- Left load:
  - If the holding register is full: left word = sample_l, latch sample_r as the right staging word, empty the holding register, and pulse frame_start.
  - If the holding register is empty: left word = 0, right staging = 0, pulse underflow, increment underflow_cnt (saturating at 16'hFFFF), and pulse frame_start.
  - Simultaneous transfer and left load on the same edge: the load sees the holding register as empty, so an underflow is reported. The new pair is stored and used in the next frame.
- Right load: right word = right staging word. Right staging is never taken from the holding register.
- Word layout:
  - The DATA_W data bits occupy the first DATA_W bit periods after the delay slot.
  - The remaining SLOT_W - DATA_W bit periods, including the next delay slot, carry 0.
- Timing drift: lr_edge always forces the reload, even if the bit count disagrees with SLOT_W. There is no error state.
- Latency: dacdat changes 1 clk after bclk_fall detection, which is at most SYNC_STAGES + 2 clk cycles after the pin's falling edge.

Optional Feature:
- Macro: I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: the load happens on the same bclk_fall as lr_edge (no one-bclk delay), giving left-justified format. The MSB appears on the bclk fall where lrclk toggles.
- Undefined: standard I2S one-bclk delay as described above.

Test Plan:
- Reset release, no data, lrclk 1 to 0 -> sample_ready=1 after 1 clk. IDLE exits; left slot dacdat all 0; underflow pulses once; underflow_cnt=1.
- Push L=24'hA5F00F, R=24'h5A0FF0 before a left edge -> sample_ready drops next clk. Per slot, after a 1-bclk delay, dacdat = 101001011111000000001111 then 8 zeros. The right slot carries 010110100000111111110000. frame_start pulses once.
- Back-to-back pushes with sample_valid held 1 -> exactly one pair accepted per frame, sample_ready high once per frame, underflow_cnt unchanged over 16 frames.
- Push on the same clk edge as the left load -> underflow=1 and the frame carries zeros. The next frame carries the pushed pair.
- Assert reset_n=0 for 3 clk mid left word -> dacdat=0 immediately, holding cleared, underflow_cnt=0. Correct output resumes from the next left slot only.
- With I2S_TX_LEFT_JUSTIFIED_EN defined and L=24'h800000 -> dacdat=1 in the first bit period of the left slot, 0 thereafter.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S DAC-side transmitter, codec is bus master (bclk/lrclk async inputs)
// Optional build macro: I2S_TX_LEFT_JUSTIFIED_EN (load on the lrclk edge itself, left-justified format)
module i2s_tx_serializer #(
    parameter int DATA_W      = 24,
    parameter int SLOT_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dacdat,
    output logic              frame_start,
    output logic              underflow,
    output logic [15:0]       underflow_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrclk_sync;
    logic                   bclk_prev;
    logic                   bclk_s;
    logic                   lrclk_s;
    logic                   bclk_fall;
    logic                   lr_prev;
    logic                   lr_primed;
    logic                   lr_edge;
    logic                   edge_ok;
    logic [1:0]             state;
    logic                   hold_full;
    logic [DATA_W-1:0]      hold_l;
    logic [DATA_W-1:0]      hold_r;
    logic [DATA_W-1:0]      right_stage;
    logic [DATA_W-1:0]      shreg;
    logic                   transfer;
    logic                   load_now;
    logic                   load_is_left;
    logic                   left_load;
    logic                   right_load;

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lrclk_s   = lrclk_sync[SYNC_STAGES-1];
    assign bclk_fall = bclk_prev & ~bclk_s;
    // The first bclk fall after reset only records lrclk, so a stale reset
    // value can never fake a channel edge mid-slot.
    assign lr_edge   = bclk_fall & lr_primed & (lrclk_s != lr_prev);
    // While idle, only a transition into the left slot starts the stream.
    assign edge_ok   = lr_edge & ((state != ST_IDLE) | ~lrclk_s);
    assign transfer  = sample_valid & sample_ready;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    assign load_now     = edge_ok;
    assign load_is_left = ~lrclk_s;
`else
    logic load_armed;
    logic load_left;

    assign load_now     = bclk_fall & load_armed;
    assign load_is_left = load_left;

    // Arm on the channel edge, load one bclk later (I2S delay slot)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_armed <= 1'b0;
            load_left  <= 1'b0;
        end else if (bclk_fall) begin
            load_armed <= edge_ok;
            if (edge_ok) begin
                load_left <= ~lrclk_s;
            end
        end
    end
`endif

    assign left_load  = load_now & load_is_left;
    assign right_load = load_now & ~load_is_left;

    // Bring bclk/lrclk into the clk domain and track lrclk at each bclk fall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            bclk_prev  <= 1'b0;
            lr_prev    <= 1'b0;
            lr_primed  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
            bclk_prev  <= bclk_s;
            if (bclk_fall) begin
                lr_prev   <= lrclk_s;
                lr_primed <= 1'b1;
            end
        end
    end

    // Single-entry holding register; a left load that coincides with a
    // transfer sees it empty and the new pair waits for the next frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full    <= 1'b0;
            hold_l       <= '0;
            hold_r       <= '0;
            sample_ready <= 1'b0;
        end else begin
            if (transfer) begin
                hold_full <= 1'b1;
                hold_l    <= sample_l;
                hold_r    <= sample_r;
            end else if (left_load) begin
                hold_full <= 1'b0;
            end
            sample_ready <= ~(transfer | (hold_full & ~left_load));
        end
    end

    // Slot FSM, shift register and event reporting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            right_stage   <= '0;
            dacdat        <= 1'b0;
            frame_start   <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= 16'd0;
        end else begin
            frame_start <= left_load;
            underflow   <= left_load & ~hold_full;
            if (left_load && !hold_full && underflow_cnt != 16'hFFFF) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
            if (left_load) begin
                state       <= ST_LEFT;
                shreg       <= hold_full ? hold_l : '0;
                right_stage <= hold_full ? hold_r : '0;
                dacdat      <= hold_full ? hold_l[DATA_W-1] : 1'b0;
            end else if (right_load) begin
                state  <= ST_RIGHT;
                shreg  <= right_stage;
                dacdat <= right_stage[DATA_W-1];
            end else if (bclk_fall && state != ST_IDLE) begin
                shreg  <= {shreg[DATA_W-2:0], 1'b0};
                dacdat <= shreg[DATA_W-2];
            end
        end
    end

endmodule
